pipeline_ctrl: RTL and testbench

//  Central stall/bubble/redirect controller for the 5-stage pipeline. Owns hold/flush of the IF_ID register.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 30 +++
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/bubble/redirect controller.
//   - Stage indices into the stall bus (PC .. MEM_WB).
//   - Stall bus width and the fixed stall patterns used by each hazard row.
//   - Controller FSM state encoding.
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  // Stage indices into the stall bus
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  localparam int STALL_W = 5;

  // Stall patterns per hazard row
  localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
  localparam logic [STALL_W-1:0] STALL_ALL  = 5'b11111;  // fatal: freeze everything
  localparam logic [STALL_W-1:0] STALL_MEM  = 5'b01111;  // hold PC..EX_MEM, MEM_WB gets nop
  localparam logic [STALL_W-1:0] STALL_LU   = 5'b00011;  // hold PC and IF_ID, ID_EX gets nop

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Hazard inputs and pipeline control outputs shared between the datapath
// (master) and the stall controller (slave).
//   Hazard sources  : if_rom_ready, id_load_use, id_branch_taken,
//                     id_branch_target[31:0], mem_req, mem_ack
//   Control outputs : stall[4:0], flush_if_id, bubble_id_ex, bubble_mem_wb,
//                     pc_redirect, pc_redirect_target[31:0], mem_timeout
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic                if_rom_ready;
  logic                id_load_use;
  logic                id_branch_taken;
  logic [31:0]         id_branch_target;
  logic                mem_req;
  logic                mem_ack;

  logic [STALL_W-1:0]  stall;
  logic                flush_if_id;
  logic                bubble_id_ex;
  logic                bubble_mem_wb;
  logic                pc_redirect;
  logic [31:0]         pc_redirect_target;
  logic                mem_timeout;

  // Datapath side: reports hazards, consumes control
  modport master (
    output if_rom_ready, id_load_use, id_branch_taken, id_branch_target,
           mem_req, mem_ack,
    input  stall, flush_if_id, bubble_id_ex, bubble_mem_wb,
           pc_redirect, pc_redirect_target, mem_timeout
  );

  // Controller side
  modport slave (
    input  if_rom_ready, id_load_use, id_branch_taken, id_branch_target,
           mem_req, mem_ack,
    output stall, flush_if_id, bubble_id_ex, bubble_mem_wb,
           pc_redirect, pc_redirect_target, mem_timeout
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the controller performance counters.
//   clk   in  1      clock
//   rst   in  1      synchronous reset, active-low
//   i_inc in  1      count this cycle
//   o_q   out CNT_W  count value; sticks at all-ones, never wraps
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/bubble/redirect controller for the 5-stage pipeline.
// Arbitrates data-mem wait, instruction-ROM wait, load-use and taken
// branch/jump, drives per-stage stall bits, bubble strobes and the PC
// redirect, watches for a stuck data memory and keeps two saturating
// performance counters.
//
// Ports
//   clk             in   1      system clock
//   rst             in   1      synchronous reset, active-low
//   ctl             slave modport of pipeline_ctrl_if (hazards in, control out)
//   o_stall_cycles  out  CNT_W  cycles with any stall bit set
//   o_bubble_count  out  CNT_W  cycles with any bubble/flush strobe set
//
// States
//   state       | meaning
//   ------------+---------------------------------------------------------
//   RUN         | normal flow; a MEM wait this cycle moves to MEM_WAIT
//   MEM_WAIT    | data memory stalled; r_wait_cnt counts un-acked cycles
//   ERR         | watchdog expired; pipeline frozen until reset
//
// Control outputs are combinational from state + hazard inputs so a hazard
// stalls the pipeline in the same cycle it is reported.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_ctrl_if.slave      ctl,
  output logic [CNT_W-1:0]    o_stall_cycles,
  output logic [CNT_W-1:0]    o_bubble_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t         r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic                w_mem_wait;
  logic [STALL_W-1:0]  w_stall;
  logic                w_flush_if_id;
  logic                w_bubble_id_ex;
  logic                w_bubble_mem_wb;
  logic                w_pc_redirect;
  logic [31:0]         w_pc_redirect_target;
  logic                w_mem_timeout;
  logic                w_any_stall;
  logic                w_any_bubble;

  assign w_mem_wait = ctl.mem_req && !ctl.mem_ack;

  // -------------------------------------------------------------------------
  // FSM + MEM-wait watchdog
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wait_cnt <= '0;
          if (w_mem_wait) begin
            r_state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (ctl.mem_ack || !ctl.mem_req) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state <= ST_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Hazard arbitration; only the highest-priority active row drives outputs.
  // A suppressed branch is not lost: ID is held, so it re-presents next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    w_stall              = STALL_NONE;
    w_flush_if_id        = 1'b0;
    w_bubble_id_ex       = 1'b0;
    w_bubble_mem_wb      = 1'b0;
    w_pc_redirect        = 1'b0;
    w_pc_redirect_target = 32'h0;
    w_mem_timeout        = 1'b0;
    if (rst) begin
      if (r_state == ST_ERR) begin
        w_stall       = STALL_ALL;
        w_mem_timeout = 1'b1;
      end else if (w_mem_wait) begin
        w_stall         = STALL_MEM;
        w_bubble_mem_wb = 1'b1;
      end else if (!ctl.if_rom_ready) begin
        // Hold PC and feed a nop into IF_ID until the ROM delivers.
        w_stall[STG_PC] = 1'b1;
        w_flush_if_id   = 1'b1;
      end else if (ctl.id_load_use) begin
        w_stall        = STALL_LU;
        w_bubble_id_ex = 1'b1;
      end else if (ctl.id_branch_taken) begin
        // Delay slot is architected, so the fetched instruction is kept.
        w_pc_redirect        = 1'b1;
        w_pc_redirect_target = ctl.id_branch_target;
      end
    end
  end

  assign ctl.stall              = w_stall;
  assign ctl.flush_if_id        = w_flush_if_id;
  assign ctl.bubble_id_ex       = w_bubble_id_ex;
  assign ctl.bubble_mem_wb      = w_bubble_mem_wb;
  assign ctl.pc_redirect        = w_pc_redirect;
  assign ctl.pc_redirect_target = w_pc_redirect_target;
  assign ctl.mem_timeout        = w_mem_timeout;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  assign w_any_stall  = |w_stall;
  assign w_any_bubble = w_flush_if_id | w_bubble_id_ex | w_bubble_mem_wb;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_any_stall),
    .o_q   (o_stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_any_bubble),
    .o_q   (o_bubble_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed and random stimulus for pipeline_ctrl. Expected responses come
// from a behavioural model of the hazard priority rules and are queued; a
// monitor compares them against the DUT outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int MT = 4;
  localparam int CW = 6;

  typedef struct packed {
    logic [4:0]    stall;
    logic          flush;
    logic          bie;
    logic          bmw;
    logic          redir;
    logic [31:0]   tgt;
    logic          to;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] bubble_count;

  pipeline_ctrl_if u_if ();

  pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ctl            (u_if),
    .o_stall_cycles (stall_cycles),
    .o_bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  logic          m_err    = 1'b0;
  int            m_streak = 0;   // consecutive cycles of mem_req && !mem_ack
  logic [CW-1:0] m_sc     = '0;
  logic [CW-1:0] m_bc     = '0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  task automatic step(input logic r, input logic rom, input logic lu,
                      input logic br, input logic [31:0] t,
                      input logic rq, input logic ak);
    exp_t e;
    logic w;
    @(posedge clk);
    #1;
    rst                       = r;
    u_if.if_rom_ready         = rom;
    u_if.id_load_use          = lu;
    u_if.id_branch_taken      = br;
    u_if.id_branch_target     = t;
    u_if.mem_req              = rq;
    u_if.mem_ack              = ak;

    e    = '0;
    e.sc = m_sc;
    e.bc = m_bc;
    w    = rq && !ak;
    if (r) begin
      if (m_err) begin
        e.stall = 5'b11111;
        e.to    = 1'b1;
      end else if (w) begin
        e.stall = 5'b01111;
        e.bmw   = 1'b1;
      end else if (!rom) begin
        e.stall = 5'b00001;
        e.flush = 1'b1;
      end else if (lu) begin
        e.stall = 5'b00011;
        e.bie   = 1'b1;
      end else if (br) begin
        e.redir = 1'b1;
        e.tgt   = t;
      end
    end
    exp_q.push_back(e);

    if (!r) begin
      m_sc     = '0;
      m_bc     = '0;
      m_err    = 1'b0;
      m_streak = 0;
    end else begin
      if (e.stall != 5'b0)            m_sc = sat_inc(m_sc);
      if (e.flush || e.bie || e.bmw)  m_bc = sat_inc(m_bc);
      if (!m_err) begin
        if (w) begin
          m_streak++;
          // First un-acked cycle is seen in RUN, then MT cycles in MEM_WAIT.
          if (m_streak == MT + 1) m_err = 1'b1;
        end else begin
          m_streak = 0;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e       = exp_q.pop_front();
        a.stall = u_if.stall;
        a.flush = u_if.flush_if_id;
        a.bie   = u_if.bubble_id_ex;
        a.bmw   = u_if.bubble_mem_wb;
        a.redir = u_if.pc_redirect;
        a.tgt   = u_if.pc_redirect_target;
        a.to    = u_if.mem_timeout;
        a.sc    = stall_cycles;
        a.bc    = bubble_count;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t got stall=%b fl=%b bie=%b bmw=%b rd=%b tgt=%h to=%b sc=%0d bc=%0d exp stall=%b fl=%b bie=%b bmw=%b rd=%b tgt=%h to=%b sc=%0d bc=%0d",
                   $time, a.stall, a.flush, a.bie, a.bmw, a.redir, a.tgt, a.to, a.sc, a.bc,
                   e.stall, e.flush, e.bie, e.bmw, e.redir, e.tgt, e.to, e.sc, e.bc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   drain;
    logic lo_ack;
    u_if.if_rom_ready     = 1'b1;
    u_if.id_load_use      = 1'b1;
    u_if.id_branch_taken  = 1'b1;
    u_if.id_branch_target = 32'hFFFF_FFFF;
    u_if.mem_req          = 1'b1;
    u_if.mem_ack          = 1'b1;
    rst                   = 1'b0;
    @(posedge clk);   // one reset edge before the model takes over

    // Reset held 3 cycles with all inputs high
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    idle();

    // Load-use single cycle, then counters show 1/1
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();

    // Taken branch
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);

    // Load-use + branch, then branch alone
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);

    // ROM wait with a taken branch: redirect suppressed
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0);

    // MEM wait, acked on the fourth cycle
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle();

    // Same-cycle ack: no stall
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle();

    // Watchdog: never acked -> ERR held, then cleared by reset
    repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);

    // Reset mid MEM_WAIT
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();

    // Randomized traffic; low-ack phases exercise the watchdog
    lo_ack = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ((i % 25) == 0) lo_ack = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           $urandom(),
           lo_ack ? 1'b1 : ($urandom_range(0, 2) == 0),
           lo_ack ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 0));
    end
    idle();

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
